spi_tgt_regfile: RTL and testbench

- SPI target (mode 0, CPOL=0/CPHA=0) that sits on the far end of the SoC SPI host bus (`spih_*`).
- Gives the host byte-addressed read/write access to a small local register file.
- Used as an on-FPGA peer for SPI host bring-up, and as a config block for board glue.
- SPI pins are oversampled in the system clock domain; clk_i must be at least 8x SCK.

---
 rtl/spi_tgt_pkg.sv | 14 +
 rtl/spi_tgt_sync.sv | 41 ++++
 rtl/spi_tgt_regfile.sv | 179 +++++++++++++++++
 tb/tb_spi_tgt_regfile.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/spi_tgt_pkg.sv
// Shared types and constants for the SPI target register file.
package spi_tgt_pkg;

  localparam int unsigned AddrWidth  = 7;
  localparam int unsigned CmdReadBit = 7;

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    WDATA,
    RDATA
  } spi_tgt_state_e;

endpackage

// File: rtl/spi_tgt_sync.sv
// Synchronizes sck/csb/mosi into clk_i and detects sck edges on the synced clock.
module spi_tgt_sync #(
  parameter int unsigned SyncStages = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic spi_sck_i,
  input  logic spi_csb_i,
  input  logic spi_mosi_i,
  output logic sck_rise_o,
  output logic sck_fall_o,
  output logic csb_s_o,
  output logic mosi_s_o
);

  logic [SyncStages-1:0] r_sck;
  logic [SyncStages-1:0] r_csb;
  logic [SyncStages-1:0] r_mosi;
  logic                  r_sck_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_sck   <= '0;
      r_csb   <= '1;
      r_mosi  <= '0;
      r_sck_q <= 1'b0;
    end else begin
      r_sck   <= {r_sck[SyncStages-2:0], spi_sck_i};
      r_csb   <= {r_csb[SyncStages-2:0], spi_csb_i};
      r_mosi  <= {r_mosi[SyncStages-2:0], spi_mosi_i};
      r_sck_q <= r_sck[SyncStages-1];
    end
  end

  // Edges are taken after the full chain so mosi at the same depth lines up with them.
  assign sck_rise_o = r_sck[SyncStages-1] & ~r_sck_q;
  assign sck_fall_o = ~r_sck[SyncStages-1] & r_sck_q;
  assign csb_s_o    = r_csb[SyncStages-1];
  assign mosi_s_o   = r_mosi[SyncStages-1];

endmodule

// File: rtl/spi_tgt_regfile.sv
// SPI mode-0 target giving byte-addressed access to a local register file.
// Optional write-completion interrupt is enabled by defining SPI_TGT_IRQ_EN.
module spi_tgt_regfile
  import spi_tgt_pkg::*;
#(
  parameter int unsigned NumRegs    = 16,
  parameter int unsigned SyncStages = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 spi_sck_i,
  input  logic                 spi_csb_i,
  input  logic                 spi_mosi_i,
  output logic                 spi_miso_o,
  output logic                 spi_miso_oe_o,
  output logic [NumRegs*8-1:0] regs_o,
  output logic                 wr_valid_o,
  output logic [6:0]           wr_addr_o,
  output logic [7:0]           wr_data_o
`ifdef SPI_TGT_IRQ_EN
  ,
  input  logic                 irq_clr_i,
  output logic                 irq_o
`endif
);

  logic w_sck_rise;
  logic w_sck_fall;
  logic w_csb_s;
  logic w_mosi_s;

  spi_tgt_sync #(
    .SyncStages(SyncStages)
  ) u_sync (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .spi_sck_i  (spi_sck_i),
    .spi_csb_i  (spi_csb_i),
    .spi_mosi_i (spi_mosi_i),
    .sck_rise_o (w_sck_rise),
    .sck_fall_o (w_sck_fall),
    .csb_s_o    (w_csb_s),
    .mosi_s_o   (w_mosi_s)
  );

  spi_tgt_state_e         r_state;
  logic [2:0]             r_bitcnt;
  logic [6:0]             r_rx;
  logic [7:0]             r_tx;
  logic [AddrWidth-1:0]   r_addr;
  logic                   r_oe;
  logic [NumRegs*8-1:0]   r_regs;
  logic                   r_wr_valid;
  logic [AddrWidth-1:0]   r_wr_addr;
  logic [7:0]             r_wr_data;

  logic [7:0]             w_byte;
  logic                   w_byte_done;
  logic [AddrWidth-1:0]   w_rd_addr;
  logic [7:0]             w_rd_byte;

  assign w_byte      = {r_rx, w_mosi_s};
  assign w_byte_done = w_sck_rise && (r_bitcnt == 3'd7);

  // The command byte's own address feeds the first read before r_addr is loaded.
  assign w_rd_addr = (r_state == CMD) ? w_byte[AddrWidth-1:0] : r_addr;

  always_comb begin
    w_rd_byte = '0;
    for (int unsigned i = 0; i < NumRegs; i++) begin
      if (w_rd_addr == AddrWidth'(i)) begin
        w_rd_byte = r_regs[i*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= IDLE;
      r_bitcnt   <= '0;
      r_rx       <= '0;
      r_tx       <= '0;
      r_addr     <= '0;
      r_oe       <= 1'b0;
      r_wr_valid <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
    end else begin
      r_wr_valid <= 1'b0;
      if (w_csb_s) begin
        r_state  <= IDLE;
        r_bitcnt <= '0;
        r_oe     <= 1'b0;
      end else if (r_state == IDLE) begin
        r_state  <= CMD;
        r_bitcnt <= '0;
      end else begin
        if (w_sck_rise) begin
          r_bitcnt <= r_bitcnt + 3'd1;
          r_rx     <= w_byte[6:0];
        end else if (w_sck_fall && (r_bitcnt != 3'd0)) begin
          r_tx <= {r_tx[6:0], 1'b0};
        end
        if (w_byte_done) begin
          unique case (r_state)
            CMD: begin
              if (w_byte[CmdReadBit]) begin
                r_state <= RDATA;
                r_oe    <= 1'b1;
                r_tx    <= w_rd_byte;
                r_addr  <= w_byte[AddrWidth-1:0] + 7'd1;
              end else begin
                r_state <= WDATA;
                r_addr  <= w_byte[AddrWidth-1:0];
              end
            end
            WDATA: begin
              r_wr_valid <= 1'b1;
              r_wr_addr  <= r_addr;
              r_wr_data  <= w_byte;
              r_addr     <= r_addr + 7'd1;
            end
            RDATA: begin
              r_tx   <= w_rd_byte;
              r_addr <= r_addr + 7'd1;
            end
            default: begin
            end
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_regs <= '0;
    end else if (!w_csb_s && (r_state == WDATA) && w_byte_done) begin
      for (int unsigned i = 0; i < NumRegs; i++) begin
        if (r_addr == AddrWidth'(i)) begin
          r_regs[i*8 +: 8] <= w_byte;
        end
      end
    end
  end

`ifdef SPI_TGT_IRQ_EN
  logic r_wrote;
  logic r_irq;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wrote <= 1'b0;
      r_irq   <= 1'b0;
    end else begin
      if (r_state == IDLE) begin
        r_wrote <= 1'b0;
      end else if (r_wr_valid) begin
        r_wrote <= 1'b1;
      end
      if (w_csb_s && (r_state != IDLE) && (r_wrote || r_wr_valid)) begin
        r_irq <= 1'b1;
      end else if (irq_clr_i) begin
        r_irq <= 1'b0;
      end
    end
  end

  assign irq_o = r_irq;
`endif

  assign spi_miso_o    = r_oe & r_tx[7];
  assign spi_miso_oe_o = r_oe;
  assign regs_o        = r_regs;
  assign wr_valid_o    = r_wr_valid;
  assign wr_addr_o     = r_wr_addr;
  assign wr_data_o     = r_wr_data;

endmodule

// File: tb/tb_spi_tgt_regfile.sv
// Scoreboard bench for spi_tgt_regfile: one 16-register and one 128-register instance on a shared bus.
module tb_spi_tgt_regfile;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst_n;
  logic               sck;
  logic               mosi;
  logic               csb   [2];
  logic               miso  [2];
  logic               oe    [2];
  logic               wv    [2];
  logic [6:0]         wa    [2];
  logic [7:0]         wd    [2];
  logic [16*8-1:0]    regs0;
  logic [128*8-1:0]   regs1;
`ifdef SPI_TGT_IRQ_EN
  logic               irq_clr [2];
  logic               irq     [2];
`endif

  spi_tgt_regfile #(.NumRegs(16), .SyncStages(2)) u_dut0 (
    .clk_i(clk), .rst_ni(rst_n), .spi_sck_i(sck), .spi_csb_i(csb[0]), .spi_mosi_i(mosi),
    .spi_miso_o(miso[0]), .spi_miso_oe_o(oe[0]), .regs_o(regs0),
    .wr_valid_o(wv[0]), .wr_addr_o(wa[0]), .wr_data_o(wd[0])
`ifdef SPI_TGT_IRQ_EN
    , .irq_clr_i(irq_clr[0]), .irq_o(irq[0])
`endif
  );

  spi_tgt_regfile #(.NumRegs(128), .SyncStages(2)) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n), .spi_sck_i(sck), .spi_csb_i(csb[1]), .spi_mosi_i(mosi),
    .spi_miso_o(miso[1]), .spi_miso_oe_o(oe[1]), .regs_o(regs1),
    .wr_valid_o(wv[1]), .wr_addr_o(wa[1]), .wr_data_o(wd[1])
`ifdef SPI_TGT_IRQ_EN
    , .irq_clr_i(irq_clr[1]), .irq_o(irq[1])
`endif
  );

  typedef struct { int inst; logic [6:0] a; logic [7:0] d; } wr_t;
  typedef struct { int inst; logic [7:0] d; } rd_t;
  wr_t wr_q[$];
  rd_t rd_q[$];

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] m0 [16];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- monitors ----------------
  for (genvar g = 0; g < 2; g++) begin : g_mon
    initial begin : rd_mon
      int bits;
      int nbyte;
      logic [7:0] sh;
      logic oe_seen;
      rd_t e;
      bits = 0; nbyte = 0; sh = '0; oe_seen = 1'b0;
      forever begin
        @(posedge sck or posedge csb[g]);
        if (csb[g] !== 1'b0) begin
          bits = 0; nbyte = 0; oe_seen = 1'b0;
        end else begin
          sh      = {sh[6:0], miso[g]};
          oe_seen = oe_seen | oe[g];
          bits++;
          if (bits == 8) begin
            bits = 0;
            if (nbyte == 0) begin
              chk($sformatf("cmd_quiet%0d", g), {55'd0, oe_seen, sh}, 64'd0);
            end else if (oe_seen) begin
              if (rd_q.size() == 0 || rd_q[0].inst != g) begin
                n_tests++; n_fail++;
                $display("FAIL rd_unexpected%0d: got byte %0h, expected no read data", g, sh);
              end else begin
                e = rd_q.pop_front();
                chk($sformatf("rd_byte%0d", g), {56'd0, sh}, {56'd0, e.d});
              end
            end else begin
              chk($sformatf("miso_quiet%0d", g), {56'd0, sh}, 64'd0);
            end
            nbyte++;
            oe_seen = 1'b0;
          end
        end
      end
    end

    initial begin : wr_mon
      wr_t e;
      forever begin
        @(negedge clk);
        if (rst_n === 1'b1 && wv[g] === 1'b1) begin
          if (wr_q.size() == 0 || wr_q[0].inst != g) begin
            n_tests++; n_fail++;
            $display("FAIL wr_unexpected%0d: got addr %0h data %0h, expected no write", g, wa[g], wd[g]);
          end else begin
            e = wr_q.pop_front();
            chk($sformatf("wr_addr%0d", g), {57'd0, wa[g]}, {57'd0, e.a});
            chk($sformatf("wr_data%0d", g), {56'd0, wd[g]}, {56'd0, e.d});
          end
        end
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic sck_bit(input logic b);
    mosi = b;
    repeat (4) @(negedge clk);
    sck = 1'b1;
    repeat (4) @(negedge clk);
    sck = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int nbits);
    for (int i = 0; i < nbits; i++) sck_bit(b[7-i]);
  endtask

  task automatic begin_frame(input int inst);
    csb[inst] = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic end_frame(input int inst);
    repeat (4) @(negedge clk);
    csb[inst] = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic push_wr(input int inst, input logic [6:0] a, input logic [7:0] d);
    wr_t e;
    e.inst = inst; e.a = a; e.d = d;
    wr_q.push_back(e);
    if (inst == 0 && a < 7'd16) m0[a[3:0]] = d;
  endtask

  task automatic push_rd(input int inst, input logic [7:0] d);
    rd_t e;
    e.inst = inst; e.d = d;
    rd_q.push_back(e);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, expected completion within 1ms");
    $fatal(1);
  end

  initial begin
    logic [7:0] got;
    rst_n = 1'b0; sck = 1'b0; mosi = 1'b0; csb[0] = 1'b1; csb[1] = 1'b1;
`ifdef SPI_TGT_IRQ_EN
    irq_clr[0] = 1'b0; irq_clr[1] = 1'b0;
`endif
    for (int i = 0; i < 16; i++) m0[i] = 8'h00;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    chk("rst_regs0", {63'd0, |regs0}, 64'd0);
    chk("rst_regs1", {63'd0, |regs1}, 64'd0);
    chk("rst_outs0", {47'd0, miso[0], oe[0], wv[0], wa[0], wd[0]}, 64'd0);
    chk("rst_outs1", {47'd0, miso[1], oe[1], wv[1], wa[1], wd[1]}, 64'd0);
`ifdef SPI_TGT_IRQ_EN
    chk("rst_irq", {63'd0, irq[0]}, 64'd0);
`endif

    // Basic write with auto-increment
    push_wr(0, 7'h03, 8'hA5);
    push_wr(0, 7'h04, 8'h5A);
    begin_frame(0); send_byte(8'h03, 8); send_byte(8'hA5, 8); send_byte(8'h5A, 8); end_frame(0);
    chk("reg3", {56'd0, regs0[3*8 +: 8]}, 64'hA5);
    chk("reg4", {56'd0, regs0[4*8 +: 8]}, 64'h5A);

    // Preload then read back, dummy bytes must not write
    push_wr(0, 7'h00, 8'h11); push_wr(0, 7'h01, 8'h22); push_wr(0, 7'h02, 8'h33);
    begin_frame(0); send_byte(8'h00, 8); send_byte(8'h11, 8); send_byte(8'h22, 8); send_byte(8'h33, 8); end_frame(0);
    push_rd(0, 8'h11); push_rd(0, 8'h22); push_rd(0, 8'h33);
    begin_frame(0); send_byte(8'h80, 8); send_byte(8'hFF, 8); send_byte(8'hFF, 8); send_byte(8'hFF, 8); end_frame(0);

    // Last valid register, then out-of-range address
    push_wr(0, 7'h0F, 8'h77);
    push_wr(0, 7'h10, 8'h88);
    begin_frame(0); send_byte(8'h0F, 8); send_byte(8'h77, 8); send_byte(8'h88, 8); end_frame(0);
    chk("reg15", {56'd0, regs0[15*8 +: 8]}, 64'h77);

    // Address wrap on a 128-register instance
    push_wr(1, 7'h7F, 8'hC3);
    push_wr(1, 7'h00, 8'h3C);
    begin_frame(1); send_byte(8'h7F, 8); send_byte(8'hC3, 8); send_byte(8'h3C, 8); end_frame(1);
    push_rd(1, 8'hC3); push_rd(1, 8'h3C);
    begin_frame(1); send_byte(8'hFF, 8); send_byte(8'h00, 8); send_byte(8'h00, 8); end_frame(1);
    chk("reg127_1", {56'd0, regs1[127*8 +: 8]}, 64'hC3);
    chk("reg0_1", {56'd0, regs1[7:0]}, 64'h3C);

    // Aborted byte, then a clean frame
    begin_frame(0); send_byte(8'h02, 8); send_byte(8'hEE, 5); end_frame(0);
    chk("reg2_after_abort", {56'd0, regs0[2*8 +: 8]}, 64'h33);
    push_wr(0, 7'h05, 8'h99);
    begin_frame(0); send_byte(8'h05, 8); send_byte(8'h99, 8); end_frame(0);

`ifdef SPI_TGT_IRQ_EN
    irq_clr[0] = 1'b1; @(negedge clk); irq_clr[0] = 1'b0; @(negedge clk);
    chk("irq_cleared", {63'd0, irq[0]}, 64'd0);
    push_wr(0, 7'h06, 8'h42);
    begin_frame(0); send_byte(8'h06, 8); send_byte(8'h42, 8); end_frame(0);
    chk("irq_set", {63'd0, irq[0]}, 64'd1);
    irq_clr[0] = 1'b1; @(negedge clk); irq_clr[0] = 1'b0; @(negedge clk);
    chk("irq_clr", {63'd0, irq[0]}, 64'd0);
    push_rd(0, 8'h42);
    begin_frame(0); send_byte(8'h86, 8); send_byte(8'h00, 8); end_frame(0);
    chk("irq_read_only", {63'd0, irq[0]}, 64'd0);
`endif

    repeat (10) @(negedge clk);
    chk("wr_q_empty", 64'(wr_q.size()), 64'd0);
    chk("rd_q_empty", 64'(rd_q.size()), 64'd0);
    for (int i = 0; i < 16; i++) begin
      got = regs0[i*8 +: 8];
      chk($sformatf("final_reg%0d", i), {56'd0, got}, {56'd0, m0[i]});
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
